time_entry_loader: RTL and testbench

- Keypad-to-timer loading stage; sits directly upstream of the mod-6/mod-10 countdown counter chain.
- Collects BCD digits from the keypad encoder into a 3-digit M:SS entry buffer and presents them on the counters' parallel-load inputs.
- Issues the counters' active-low load strobe, then gates their count enable from the 1 Hz tick until the chain reaches zero.

---
 rtl/time_entry_loader.sv | 143 ++++++++++++++
 tb/tb_time_entry_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_loader.sv
// Keypad entry buffer and load/enable sequencer for the M:SS countdown counter chain.
// Optional ENTRY_TIMEOUT_EN macro adds an idle auto-clear timer in ENTRY.
module time_entry_loader #(
    parameter logic [3:0] MAX_TENS       = 4'd5,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       cancel,
    input  logic       tick,
    input  logic       timer_zero,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] minutes,
    output logic       loadn,
    output logic       enable,
    output logic       running,
    output logic       done
);

    // state | meaning
    // IDLE  | buffer empty, waiting for first digit
    // ENTRY | collecting digits
    // LOAD  | one-cycle parallel load of the counters
    // RUN   | counting down, enable follows tick
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] ones_nx, tens_nx, min_nx;
    logic       ticked, ticked_nx;
    logic       cancel_pend, cancel_pend_nx;
    logic       digit_ok, buf_nonzero, run_cancel;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign digit_ok    = digit_valid && (digit_in <= 4'd9);
    assign buf_nonzero = |{minutes, sec_tens, sec_ones};
    assign run_cancel  = cancel || cancel_pend;
    assign enable      = (state == RUN) && tick && !timer_zero && !run_cancel;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Reloaded on every accepted digit; expiry is the cycle it reads zero in ENTRY.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            tmo_cnt <= '0;
        else if (digit_ok && (state == IDLE || state == ENTRY))
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        else if (state == ENTRY && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end
`endif

    always_comb begin
        state_nx       = state;
        ones_nx        = sec_ones;
        tens_nx        = sec_tens;
        min_nx         = minutes;
        ticked_nx      = ticked;
        cancel_pend_nx = 1'b0;
        case (state)
            IDLE: begin
                if (digit_ok) begin
                    min_nx   = sec_tens;
                    tens_nx  = sec_ones;
                    ones_nx  = digit_in;
                    state_nx = ENTRY;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    {min_nx, tens_nx, ones_nx} = '0;
                    state_nx = IDLE;
                end else if (start && buf_nonzero) begin
                    if (sec_tens > MAX_TENS) tens_nx = MAX_TENS;
                    state_nx = LOAD;
                end else if (digit_ok) begin
                    min_nx  = sec_tens;
                    tens_nx = sec_ones;
                    ones_nx = digit_in;
`ifdef ENTRY_TIMEOUT_EN
                end else if (tmo_cnt == '0) begin
                    {min_nx, tens_nx, ones_nx} = '0;
                    state_nx = IDLE;
`endif
                end
            end
            LOAD: begin
                ticked_nx      = 1'b0;
                cancel_pend_nx = cancel;
                state_nx       = RUN;
            end
            RUN: begin
                if (run_cancel) begin
                    {min_nx, tens_nx, ones_nx} = '0;
                    state_nx = IDLE;
                end else if (timer_zero && (tick || ticked)) begin
                    state_nx = DONE;
                end else if (tick) begin
                    ticked_nx = 1'b1;
                end
            end
            DONE: begin
                {min_nx, tens_nx, ones_nx} = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            sec_ones    <= '0;
            sec_tens    <= '0;
            minutes     <= '0;
            ticked      <= 1'b0;
            cancel_pend <= 1'b0;
            loadn       <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            sec_ones    <= ones_nx;
            sec_tens    <= tens_nx;
            minutes     <= min_nx;
            ticked      <= ticked_nx;
            cancel_pend <= cancel_pend_nx;
            loadn       <= (state_nx != LOAD);
            running     <= (state_nx == RUN);
            done        <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader with a behavioural model and a countdown-chain model.
module tb_time_entry_loader;
    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] digit_in;
    logic       digit_valid, start, cancel, tick, timer_zero;
    logic [3:0] sec_ones, sec_tens, minutes;
    logic       loadn, enable, running, done;

    localparam int TO = 8;
    localparam int MD_IDLE = 0, MD_ENTRY = 1, MD_LOAD = 2, MD_RUN = 3, MD_DONE = 4;

    time_entry_loader #(.MAX_TENS(4'd5), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .clear(clear), .digit_in(digit_in), .digit_valid(digit_valid),
        .start(start), .cancel(cancel), .tick(tick), .timer_zero(timer_zero),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .minutes(minutes),
        .loadn(loadn), .enable(enable), .running(running), .done(done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    int n_en = 0, n_done = 0;
    int cnt_sec = 0;
    logic env_loadn = 1'b1, env_enable = 1'b0;
    int env_load_val = 0;

    assign timer_zero = (cnt_sec == 0);

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, 3-digit buffer (0=minutes, 1=tens, 2=ones)
    int m_mode = MD_IDLE, m_idle = 0;
    int m_buf[3] = '{0, 0, 0};
    bit m_ticked = 0, m_cpend = 0;

    function automatic int buf_total();
        return m_buf[0] * 100 + m_buf[1] * 10 + m_buf[2];
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_mode = MD_IDLE; m_buf = '{0, 0, 0}; m_ticked = 0; m_cpend = 0; m_idle = 0;
        end else begin
            bit dv_ok, c;
            dv_ok = digit_valid && (digit_in <= 9);
            case (m_mode)
                MD_IDLE: if (dv_ok) begin
                    m_buf = '{m_buf[1], m_buf[2], int'(digit_in)};
                    m_mode = MD_ENTRY; m_idle = 0;
                end
                MD_ENTRY: begin
                    if (cancel) begin
                        m_buf = '{0, 0, 0}; m_mode = MD_IDLE;
                    end else if (start && buf_total() != 0) begin
                        if (m_buf[1] > 5) m_buf[1] = 5;
                        m_mode = MD_LOAD;
                    end else if (dv_ok) begin
                        m_buf = '{m_buf[1], m_buf[2], int'(digit_in)};
                        m_idle = 0;
                    end else begin
`ifdef ENTRY_TIMEOUT_EN
                        m_idle++;
                        if (m_idle == TO) begin
                            m_buf = '{0, 0, 0}; m_mode = MD_IDLE;
                        end
`endif
                    end
                end
                MD_LOAD: begin
                    m_mode = MD_RUN; m_ticked = 0; m_cpend = cancel;
                end
                MD_RUN: begin
                    c = cancel || m_cpend;
                    m_cpend = 0;
                    if (c) begin
                        m_buf = '{0, 0, 0}; m_mode = MD_IDLE;
                    end else if (timer_zero && (tick || m_ticked)) m_mode = MD_DONE;
                    else if (tick) m_ticked = 1;
                end
                default: begin
                    m_buf = '{0, 0, 0}; m_mode = MD_IDLE;
                end
            endcase
        end
    end

    // Downstream counter chain, total seconds; a decrement at zero would be a wrap
    always @(posedge clock) begin
        if (!env_loadn) cnt_sec <= env_load_val;
        else if (env_enable) begin
            chk("no_wrap_at_zero", int'(cnt_sec != 0), 1);
            if (cnt_sec != 0) cnt_sec <= cnt_sec - 1;
        end
    end

    always @(negedge clock) begin
        env_loadn    = loadn;
        env_enable   = enable;
        env_load_val = int'(minutes) * 60 + int'(sec_tens) * 10 + int'(sec_ones);
        if (enable) n_en++;
        if (done) n_done++;
        if (!clear) begin
            chk("minutes", minutes, m_buf[0]);
            chk("sec_tens", sec_tens, m_buf[1]);
            chk("sec_ones", sec_ones, m_buf[2]);
            chk("loadn", loadn, int'(m_mode != MD_LOAD));
            chk("running", running, int'(m_mode == MD_RUN));
            chk("done", done, int'(m_mode == MD_DONE));
            chk("enable", enable,
                int'(m_mode == MD_RUN && tick && !timer_zero && !(cancel || m_cpend)));
            chk("enable_vs_loadn", int'(enable && !loadn), 0);
        end
    end

    task automatic cyc(input logic dv, input logic [3:0] d, input logic st, input logic ca,
                       input logic tk);
        digit_valid = dv; digit_in = d; start = st; cancel = ca; tick = tk;
        @(posedge clock); #1;
        digit_valid = 0; digit_in = 0; start = 0; cancel = 0; tick = 0;
    endtask

    task automatic key(input logic [3:0] d);
        cyc(1, d, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1; digit_in = 0; digit_valid = 0; start = 0; cancel = 0; tick = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ones", sec_ones, 0); chk("rst_tens", sec_tens, 0); chk("rst_min", minutes, 0);
        chk("rst_loadn", loadn, 1); chk("rst_enable", enable, 0);
        chk("rst_running", running, 0); chk("rst_done", done, 0);
        clear = 0;

        // 1:30 load, then cancel in RUN with a tick present
        key(1); key(3); key(0); cyc(0, 0, 1, 0, 0);
        chk("l130_min", minutes, 1); chk("l130_tens", sec_tens, 3); chk("l130_ones", sec_ones, 0);
        chk("l130_loadn", loadn, 0); chk("l130_enable", enable, 0);
        idle(1);
        chk("l130_running", running, 1); chk("l130_loadn_hi", loadn, 1);
        chk("l130_counter", cnt_sec, 90);
        cancel = 1; tick = 1; #1;
        chk("cancel_run_enable", enable, 0);
        @(posedge clock); #1; cancel = 0; tick = 0;
        chk("cancel_run_running", running, 0); chk("cancel_run_buf", sec_tens, 0);
        chk("cancel_keeps_counter", cnt_sec, 90);

        // 2:95 clamps to 2:55
        key(2); key(9); key(5); cyc(0, 0, 1, 0, 0);
        chk("clamp_tens", sec_tens, 5); chk("clamp_min", minutes, 2); chk("clamp_ones", sec_ones, 5);
        idle(1);
        chk("clamp_counter", cnt_sec, 175);
        cyc(0, 0, 0, 1, 0);

        // 4 digits keep the last three; 12 ignored; zero buffer start ignored
        key(1); key(2); key(3); key(4);
        chk("shift_min", minutes, 2); chk("shift_tens", sec_tens, 3); chk("shift_ones", sec_ones, 4);
        key(12);
        chk("bad_digit_ones", sec_ones, 4); chk("bad_digit_min", minutes, 2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("idle_start_loadn", loadn, 1); chk("idle_start_running", running, 0);
        key(0); cyc(0, 0, 1, 0, 0);
        chk("zero_start_loadn", loadn, 1);
        cyc(0, 0, 0, 1, 0);

        // 0:02 countdown with three ticks
        key(2); cyc(0, 0, 1, 0, 0); idle(1);
        chk("cd_counter", cnt_sec, 2);
        n_en = 0; n_done = 0;
        cyc(0, 0, 0, 0, 1); idle(1); cyc(0, 0, 0, 0, 1); idle(1); cyc(0, 0, 0, 0, 1); idle(3);
        chk("cd_enable_pulses", n_en, 2); chk("cd_done_pulses", n_done, 1);
        chk("cd_counter_zero", cnt_sec, 0); chk("cd_running", running, 0);
        chk("cd_buf", sec_ones, 0);

        // cancel beats start in ENTRY
        key(4); key(5); cyc(0, 0, 1, 1, 0);
        chk("cs_loadn", loadn, 1); chk("cs_ones", sec_ones, 0); chk("cs_tens", sec_tens, 0);

        // start beats digit; cancel in LOAD deferred to RUN
        key(4); cyc(1, 7, 1, 0, 0);
        chk("sd_ones", sec_ones, 4); chk("sd_tens", sec_tens, 0); chk("sd_loadn", loadn, 0);
        cyc(0, 0, 0, 1, 0);
        chk("defer_running", running, 1);
        tick = 1; #1;
        chk("defer_enable", enable, 0);
        @(posedge clock); #1; tick = 0;
        chk("defer_idle", running, 0); chk("defer_counter", cnt_sec, 4);

        key(7);
`ifdef ENTRY_TIMEOUT_EN
        idle(6); key(3); idle(7);
        chk("tmo_restart_ones", sec_ones, 3); chk("tmo_restart_tens", sec_tens, 7);
        idle(1);
        chk("tmo_clear_ones", sec_ones, 0); chk("tmo_clear_tens", sec_tens, 0);
`else
        idle(20);
        chk("no_tmo_ones", sec_ones, 7);
        cyc(0, 0, 1, 0, 0);
        chk("no_tmo_load", loadn, 0);
        idle(1); cyc(0, 0, 0, 1, 0);
`endif
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
